// File: rtl/serial_word_tx_pkg.sv
// serial_word_tx_pkg
//   Shared definitions for the serial word transmitter and its matching
//   receiver: FSM state encoding (3-bit), the idle line level, and a helper
//   for sizing counters.
package serial_word_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_word_tx_bit_period_counter.sv
// bit_period_counter
//   Free-running 0..DIV-1 counter that marks the last cycle of each serial
//   bit period. Restart forces the count back to 0 so a new frame's first
//   bit period is aligned to the accept edge.
//
//   clk      in   clock
//   clr      in   asynchronous active-low reset
//   restart  in   force count to 0 on this edge
//   tick     out  high during the last cycle (count == DIV-1) of a bit period
module bit_period_counter
  import serial_word_tx_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  output logic tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With DIV=1 the count is stuck at 0 and tick is permanently high.
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_word_tx.sv
// serial_word_tx
//   Parallel-to-serial frame transmitter. Accepts an N-bit word over a
//   valid/ready handshake and sends start bit, N data bits, optional even
//   parity bit and stop bit, each held for DIV clocks.
//
//   clk       in   clock
//   clr       in   asynchronous active-low reset
//   data_in   in   word to send, sampled on the accept edge only
//   in_valid  in   producer has a word
//   in_ready  out  high only in IDLE
//   tx        out  serial line, idle high
//   busy      out  frame in progress
//   done      out  one-cycle pulse after a stop bit completes
//
//   state  | meaning
//   -------+-------------------------------------------------
//   IDLE   | line high, ready for a word (also the done cycle)
//   START  | start bit (line low)
//   DATA   | shifting out data bits, LSB of shift reg on line
//   PARITY | even parity of the captured word
//   STOP   | stop bit (line high); last tick returns to IDLE
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int N         = 8,
  parameter int DIV       = 16,
  parameter int MSB_FIRST = 0,
  parameter int PARITY_EN = 0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] data_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int BW = cnt_width(N);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          parity_q, parity_d;
  logic          done_q, done_d;
  logic          accept;
  logic          tick;
  logic [N-1:0]  load_word;

  assign accept = in_valid && (state_q == ST_IDLE);

  bit_period_counter #(.DIV(DIV)) u_bit_period_counter (
    .clk     (clk),
    .clr     (clr),
    .restart (accept),
    .tick    (tick)
  );

  // MSB-first is handled by loading the word bit-reversed, so the shift
  // path is always load / shift-right with bit 0 on the line.
  always_comb begin
    load_word = data_in;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < N; i++) begin
        load_word[i] = data_in[N-1-i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_START;
          shift_d   = load_word;
          bit_cnt_d = '0;
          parity_d  = ^data_in;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      done_q    <= done_d;
    end
  end

  // Line level decoded from registered state only, so an async reset
  // returns it high immediately.
  always_comb begin
    tx = IDLE_LEVEL;
    case (state_q)
      ST_START:  tx = ~IDLE_LEVEL;
      ST_DATA:   tx = shift_q[0];
      ST_PARITY: tx = parity_q;
      default:   tx = IDLE_LEVEL;
    endcase
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule
